// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared constants and state type for the SIFT gradient stages
package sift_pkg;

    localparam int NUM_ORIENT_BINS = 8;
    localparam int ORIENT_W        = $clog2(NUM_ORIENT_BINS);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } gmo_state_t;

endpackage

// File: rtl/grad_orient_bin.sv
// rtl/grad_orient_bin.sv - combinational (gx,gy) -> saturated magnitude and 45-degree orientation bin
// MAG_MAXMIN_EN selects max+min/2 magnitude; otherwise L1 magnitude.
module grad_orient_bin
    import sift_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic signed [BIT_DEPTH-1:0] gx,
    input  logic signed [BIT_DEPTH-1:0] gy,
    output logic        [BIT_DEPTH-1:0] mag,
    output logic        [ORIENT_W-1:0]  bin
);

    localparam logic [BIT_DEPTH+1:0] MAG_MAX = {2'b00, {BIT_DEPTH{1'b1}}};

    logic [BIT_DEPTH:0]   gx_ext, gy_ext;
    logic [BIT_DEPTH:0]   ax, ay;
    logic [BIT_DEPTH:0]   amax, amin;
    logic [BIT_DEPTH+1:0] sum;
    logic                 gx_pos, gx_neg, gy_pos, gy_neg;

    // One extra bit so that the most negative gradient has a representable magnitude.
    always_comb begin
        gx_ext = {gx[BIT_DEPTH-1], gx};
        gy_ext = {gy[BIT_DEPTH-1], gy};
        ax     = gx_ext[BIT_DEPTH] ? -gx_ext : gx_ext;
        ay     = gy_ext[BIT_DEPTH] ? -gy_ext : gy_ext;
        amax   = (ax >= ay) ? ax : ay;
        amin   = (ax >= ay) ? ay : ax;
`ifdef MAG_MAXMIN_EN
        sum    = {1'b0, amax} + {2'b00, amin[BIT_DEPTH:1]};
`else
        sum    = {1'b0, ax} + {1'b0, ay};
`endif
        mag    = (sum > MAG_MAX) ? {BIT_DEPTH{1'b1}} : sum[BIT_DEPTH-1:0];
    end

    // Boundaries fall into the higher bin, so the tie cases use >= / <= accordingly.
    always_comb begin
        gx_neg = gx[BIT_DEPTH-1];
        gy_neg = gy[BIT_DEPTH-1];
        gx_pos = !gx_neg && (gx != '0);
        gy_pos = !gy_neg && (gy != '0);
        bin    = ORIENT_W'(0);
        if (!gy_pos && !gy_neg) begin
            bin = gx_neg ? ORIENT_W'(4) : ORIENT_W'(0);
        end else if (gy_pos) begin
            if (gx_pos) bin = (ay < ax) ? ORIENT_W'(0) : ORIENT_W'(1);
            else        bin = (ay > ax) ? ORIENT_W'(2) : ORIENT_W'(3);
        end else begin
            if (gx_neg) bin = (ay < ax) ? ORIENT_W'(4) : ORIENT_W'(5);
            else        bin = (ay > ax) ? ORIENT_W'(6) : ORIENT_W'(7);
        end
    end

endmodule

// File: rtl/grad_mag_orient.sv
// rtl/grad_mag_orient.sv - streams gx/gy BRAMs and writes magnitude and orientation BRAMs
// Optional MAG_MAXMIN_EN selects the max+min/2 magnitude in grad_orient_bin.
module grad_mag_orient
    import sift_pkg::*;
#(
    parameter  int WIDTH     = 64,
    parameter  int HEIGHT    = 64,
    parameter  int BIT_DEPTH = 8,
    localparam int NPIX      = WIDTH * HEIGHT,
    localparam int AW        = $clog2(NPIX)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    output logic [AW-1:0]        x_read_addr,
    output logic                 x_read_addr_valid,
    input  logic [BIT_DEPTH-1:0] x_pixel_in,
    output logic [AW-1:0]        y_read_addr,
    output logic                 y_read_addr_valid,
    input  logic [BIT_DEPTH-1:0] y_pixel_in,
    output logic [AW-1:0]        mag_write_addr,
    output logic                 mag_write_valid,
    output logic [BIT_DEPTH-1:0] mag_pixel_out,
    output logic [AW-1:0]        orient_write_addr,
    output logic                 orient_write_valid,
    output logic [ORIENT_W-1:0]  orient_out,
    output logic                 busy_out,
    output logic                 done_out
);

    gmo_state_t           state, state_nxt;
    logic [AW-1:0]        addr, addr_nxt;
    logic                 rd_valid;
    logic                 done;
    logic                 v_d1, v_d2, wr_valid;
    logic [AW-1:0]        a_d1, a_d2, wr_addr;
    logic [BIT_DEPTH-1:0] mag_c, mag_q;
    logic [ORIENT_W-1:0]  bin_c, bin_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_nxt = STREAM;
                    addr_nxt  = '0;
                end
            end
            STREAM: begin
                if (addr == AW'(NPIX - 1)) state_nxt = DRAIN;
                else                       addr_nxt  = addr + AW'(1);
            end
            DRAIN: begin
                // Done only once the final write has left the output register.
                if (!v_d1 && !v_d2 && !wr_valid) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_valid = (state == STREAM);

    grad_orient_bin #(
        .BIT_DEPTH(BIT_DEPTH)
    ) u_bin (
        .gx  (x_pixel_in),
        .gy  (y_pixel_in),
        .mag (mag_c),
        .bin (bin_c)
    );

    // Stage 2 lines up with BRAM data; the output register is the third stage.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            v_d1     <= 1'b0;
            v_d2     <= 1'b0;
            wr_valid <= 1'b0;
            a_d1     <= '0;
            a_d2     <= '0;
            wr_addr  <= '0;
            mag_q    <= '0;
            bin_q    <= '0;
        end else begin
            v_d1     <= rd_valid;
            a_d1     <= addr;
            v_d2     <= v_d1;
            a_d2     <= a_d1;
            wr_valid <= v_d2;
            if (v_d2) begin
                wr_addr <= a_d2;
                mag_q   <= mag_c;
                bin_q   <= bin_c;
            end
        end
    end

    assign x_read_addr        = addr;
    assign y_read_addr        = addr;
    assign x_read_addr_valid  = rd_valid;
    assign y_read_addr_valid  = rd_valid;
    assign mag_write_addr     = wr_addr;
    assign orient_write_addr  = wr_addr;
    assign mag_write_valid    = wr_valid;
    assign orient_write_valid = wr_valid;
    assign mag_pixel_out      = mag_q;
    assign orient_out         = bin_q;
    assign busy_out           = (state != IDLE);
    assign done_out           = done;

endmodule

// File: tb/tb_grad_mag_orient.sv
// tb/tb_grad_mag_orient.sv - self-checking bench for grad_mag_orient on a 4x4 image
module tb_grad_mag_orient;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int BD   = 8;
    localparam int NPIX = W * H;
    localparam int AW   = $clog2(NPIX);
`ifdef MAG_MAXMIN_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          start_in = 1'b0;
    logic [AW-1:0] x_read_addr, y_read_addr, mag_write_addr, orient_write_addr;
    logic          x_read_addr_valid, y_read_addr_valid, mag_write_valid, orient_write_valid;
    logic [BD-1:0] x_pixel_in, y_pixel_in, mag_pixel_out;
    logic [2:0]    orient_out;
    logic          busy_out, done_out;

    grad_mag_orient #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .start_in           (start_in),
        .x_read_addr        (x_read_addr),
        .x_read_addr_valid  (x_read_addr_valid),
        .x_pixel_in         (x_pixel_in),
        .y_read_addr        (y_read_addr),
        .y_read_addr_valid  (y_read_addr_valid),
        .y_pixel_in         (y_pixel_in),
        .mag_write_addr     (mag_write_addr),
        .mag_write_valid    (mag_write_valid),
        .mag_pixel_out      (mag_pixel_out),
        .orient_write_addr  (orient_write_addr),
        .orient_write_valid (orient_write_valid),
        .orient_out         (orient_out),
        .busy_out           (busy_out),
        .done_out           (done_out)
    );

    always #5 clk_in = ~clk_in;

    // Two-cycle-latency gradient BRAMs
    logic [BD-1:0] gx_mem [NPIX];
    logic [BD-1:0] gy_mem [NPIX];
    logic [BD-1:0] gx_r1, gx_r2, gy_r1, gy_r2;
    always @(posedge clk_in) begin
        gx_r1 <= gx_mem[x_read_addr];
        gy_r1 <= gy_mem[y_read_addr];
        gx_r2 <= gx_r1;
        gy_r2 <= gy_r1;
    end
    assign x_pixel_in = gx_r2;
    assign y_pixel_in = gy_r2;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int mag;
        int bin;
        int cyc;
    } wr_t;
    wr_t wq[$];
    int  first_rd = -1;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  pair_err = 0;

    always @(negedge clk_in) begin
        wr_t w;
        if (mag_write_valid) begin
            w.addr = int'(mag_write_addr);
            w.mag  = int'(mag_pixel_out);
            w.bin  = int'(orient_out);
            w.cyc  = cyc;
            wq.push_back(w);
        end
        if (x_read_addr_valid && first_rd < 0) first_rd = cyc;
        if (done_out) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (x_read_addr !== y_read_addr || x_read_addr_valid !== y_read_addr_valid ||
            mag_write_addr !== orient_write_addr || mag_write_valid !== orient_write_valid)
            pair_err = pair_err + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    // Reference model: magnitude from plain arithmetic, bin from the geometric angle.
    function automatic int ref_mag(input int gx, input int gy);
        int ax, ay, m;
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        if (MM) m = ((ax > ay) ? ax : ay) + (((ax > ay) ? ay : ax) / 2);
        else    m = ax + ay;
        return (m > 255) ? 255 : m;
    endfunction

    function automatic int ref_bin(input int gx, input int gy);
        real ang;
        if (gx == 0 && gy == 0) return 0;
        if (gy == 0)   return (gx > 0) ? 0 : 4;
        if (gx == 0)   return (gy > 0) ? 2 : 6;
        if (gx == gy)  return (gx > 0) ? 1 : 5;
        if (gx == -gy) return (gy > 0) ? 3 : 7;
        ang = $atan2(real'(gy), real'(gx)) * 180.0 / 3.14159265358979;
        if (ang < 0.0) ang = ang + 360.0;
        return int'($floor(ang / 45.0));
    endfunction

    int exp_mag [NPIX];
    int exp_bin [NPIX];

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_x_addr"},  int'(x_read_addr), 0);
        chk({tag, "_x_valid"}, int'(x_read_addr_valid), 0);
        chk({tag, "_y_addr"},  int'(y_read_addr), 0);
        chk({tag, "_y_valid"}, int'(y_read_addr_valid), 0);
        chk({tag, "_w_addr"},  int'(mag_write_addr), 0);
        chk({tag, "_w_valid"}, int'(mag_write_valid), 0);
        chk({tag, "_o_valid"}, int'(orient_write_valid), 0);
        chk({tag, "_mag"},     int'(mag_pixel_out), 0);
        chk({tag, "_bin"},     int'(orient_out), 0);
        chk({tag, "_busy"},    int'(busy_out), 0);
        chk({tag, "_done"},    int'(done_out), 0);
    endtask

    task automatic run_pass(input string tag, input bit extra_start, input bit start_at_done);
        int s;
        int k;
        wq.delete();
        first_rd = -1;
        done_cnt = 0;
        pair_err = 0;
        tick();
        s = cyc;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk({tag, "_busy_after_start"}, int'(busy_out), 1);
        k = 0;
        while (done_cnt == 0 && k < 100) begin
            tick();
            k++;
            start_in = (extra_start && k == 3) ? 1'b1 : 1'b0;
        end
        chk({tag, "_done_seen"}, done_cnt, 1);
        start_in = start_at_done;
        tick();
        start_in = 1'b0;
        chk({tag, "_idle_after_done"}, int'(busy_out), 0);
        repeat (8) tick();
        chk({tag, "_write_count"}, wq.size(), NPIX);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_first_read_cyc"}, first_rd - s, 1);
        chk({tag, "_pair_err"}, pair_err, 0);
        if (wq.size() > 0) begin
            chk({tag, "_first_write_cyc"}, wq[0].cyc - s, 4);
            chk({tag, "_done_after_last"}, done_cyc - wq[wq.size()-1].cyc, 1);
        end
        for (int i = 0; i < wq.size() && i < NPIX; i++) begin
            chk($sformatf("%s_addr[%0d]", tag, i), wq[i].addr, i);
            chk($sformatf("%s_cyc[%0d]", tag, i), wq[i].cyc - wq[0].cyc, i);
            chk($sformatf("%s_mag[%0d]", tag, i), wq[i].mag, exp_mag[i]);
            chk($sformatf("%s_bin[%0d]", tag, i), wq[i].bin, exp_bin[i]);
        end
    endtask

    task automatic fill_random();
        int gx, gy;
        for (int i = 0; i < NPIX; i++) begin
            case ($urandom_range(0, 7))
                0:       gx = -128;
                1:       gx = 0;
                default: gx = int'($urandom_range(0, 255)) - 128;
            endcase
            case ($urandom_range(0, 7))
                0:       gy = -128;
                1:       gy = gx;
                2:       gy = -gx;
                3:       gy = 0;
                default: gy = int'($urandom_range(0, 255)) - 128;
            endcase
            if (gy > 127) gy = 127;
            gx_mem[i]  = gx[7:0];
            gy_mem[i]  = gy[7:0];
            exp_mag[i] = ref_mag(gx, gy);
            exp_bin[i] = ref_bin(gx, gy);
        end
    endtask

    typedef struct {
        int gx;
        int gy;
        int mag_l1;
        int mag_mm;
        int bin;
    } vec_t;

    initial begin
        vec_t tbl [NPIX];
        int   k;
        tbl = '{
            '{5, 5, 10, 7, 1},       '{0, 7, 7, 7, 2},
            '{-5, 5, 10, 7, 3},      '{-6, 0, 6, 6, 4},
            '{-5, -5, 10, 7, 5},     '{0, -3, 3, 3, 6},
            '{5, -5, 10, 7, 7},      '{0, 0, 0, 0, 0},
            '{-128, -128, 255, 192, 5}, '{20, -8, 28, 24, 7},
            '{10, 0, 10, 10, 0},     '{127, 127, 254, 190, 1},
            '{-128, 0, 128, 128, 4}, '{0, -128, 128, 128, 6},
            '{127, -128, 255, 191, 6}, '{-1, 127, 128, 127, 2}
        };

        rst_in = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_in = 1'b1;
        tick();

        // Constant gradient, with a start while busy and a start coincident with done
        for (int i = 0; i < NPIX; i++) begin
            gx_mem[i]  = 8'd10;
            gy_mem[i]  = 8'd0;
            exp_mag[i] = 10;
            exp_bin[i] = 0;
        end
        run_pass("const", 1'b1, 1'b1);

        // Directed octant and saturation vectors
        for (int i = 0; i < NPIX; i++) begin
            gx_mem[i]  = tbl[i].gx[7:0];
            gy_mem[i]  = tbl[i].gy[7:0];
            exp_mag[i] = MM ? tbl[i].mag_mm : tbl[i].mag_l1;
            exp_bin[i] = tbl[i].bin;
        end
        run_pass("table", 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            fill_random();
            run_pass($sformatf("rand%0d", r), 1'b0, 1'b0);
        end

        // Reset while pixel 6 is being read
        fill_random();
        wq.delete();
        tick();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        k = 0;
        while (!(x_read_addr_valid && x_read_addr == AW'(6)) && k < 50) begin
            tick();
            k++;
        end
        chk("midrst_reached_pixel6", int'(x_read_addr), 6);
        rst_in = 1'b0;
        #1;
        check_idle_outputs("midrst");
        tick();
        tick();
        wq.delete();
        done_cnt = 0;
        rst_in = 1'b1;
        repeat (30) tick();
        chk("midrst_no_writes", wq.size(), 0);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle", int'(busy_out), 0);

        fill_random();
        run_pass("after_rst", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
